// File: rtl/cpu_mem_bridge.sv
// CPU word-access bridge to the boot ROM and the VGA video RAM port.
// Each access ends in a single-cycle o_ack; VRAM waits are bounded.
module cpu_mem_bridge #(
    parameter logic [3:0]  ROM_BASE  = 4'hB,
    parameter int          ROM_AW    = 10,
    parameter logic [3:0]  VRAM_BASE = 4'hA,
    parameter int          VRAM_AW   = 12,
    parameter int          TIMEOUT   = 15,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req,
    input  logic               i_we,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    output logic               o_ack,
    output logic               o_err,
    output logic               o_busy,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [31:0]        rom_rdata,
    output logic               vram_req,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [31:0]        vram_wdata,
    input  logic [31:0]        vram_rdata,
    input  logic               vram_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROM_WAIT,
        S_ROM_DATA,
        S_VRAM_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        DEC_ERR,
        DEC_ROM,
        DEC_VRAM
    } dec_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;

    dec_t          w_dec;
    logic [3:0]    w_region;
    logic          w_rom_hi_ok;
    logic          w_vram_hi_ok;

    assign w_region     = i_addr[31:28];
    assign w_rom_hi_ok  = (i_addr[27:ROM_AW+2] == '0);
    assign w_vram_hi_ok = (i_addr[27:VRAM_AW+2] == '0);
    assign o_busy       = (r_state != S_IDLE);

    // Classify the presented request; earlier checks take priority.
    always_comb begin
        w_dec = DEC_ERR;
        if (i_addr[1:0] != 2'b00) begin
            w_dec = DEC_ERR;
        end else if (w_region == ROM_BASE) begin
            if (!i_we && w_rom_hi_ok) begin
                w_dec = DEC_ROM;
            end
        end else if (w_region == VRAM_BASE) begin
            if (w_vram_hi_ok) begin
                w_dec = DEC_VRAM;
            end
        end
    end

    // Access sequencer; all outputs except o_busy are registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            o_rdata    <= '0;
            o_ack      <= 1'b0;
            o_err      <= 1'b0;
            rom_addr   <= '0;
            vram_req   <= 1'b0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        case (w_dec)
                            DEC_ROM: begin
                                rom_addr <= i_addr[ROM_AW+1:2];
                                r_state  <= S_ROM_WAIT;
                            end
                            DEC_VRAM: begin
                                vram_req   <= 1'b1;
                                vram_we    <= i_we;
                                vram_addr  <= i_addr[VRAM_AW+1:2];
                                vram_wdata <= i_wdata;
                                r_cnt      <= '0;
                                r_state    <= S_VRAM_WAIT;
                            end
                            default: begin
                                o_ack   <= 1'b1;
                                o_err   <= 1'b1;
                                o_rdata <= ERR_DATA;
                                r_state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_ROM_WAIT: begin
                    r_state <= S_ROM_DATA;
                end
                S_ROM_DATA: begin
                    o_rdata <= rom_rdata;
                    o_ack   <= 1'b1;
                    r_state <= S_DONE;
                end
                S_VRAM_WAIT: begin
                    if (vram_ack) begin
                        vram_req <= 1'b0;
                        o_ack    <= 1'b1;
                        if (!vram_we) begin
                            o_rdata <= vram_rdata;
                        end
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        vram_req <= 1'b0;
                        o_ack    <= 1'b1;
                        o_err    <= 1'b1;
                        o_rdata  <= ERR_DATA;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    o_ack   <= 1'b0;
                    o_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: ROM, VRAM, timeout, errors, reset.
// Expected values are hand-derived from the address map and latencies.
module tb_cpu_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_ack;
    logic        o_err;
    logic        o_busy;
    logic [9:0]  rom_addr;
    logic [31:0] rom_rdata;
    logic        vram_req;
    logic        vram_we;
    logic [11:0] vram_addr;
    logic [31:0] vram_wdata;
    logic [31:0] vram_rdata;
    logic        vram_ack;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_rdata;
    logic [9:0]  last_rom;

    cpu_mem_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_rdata    (o_rdata),
        .o_ack      (o_ack),
        .o_err      (o_err),
        .o_busy     (o_busy),
        .rom_addr   (rom_addr),
        .rom_rdata  (rom_rdata),
        .vram_req   (vram_req),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .vram_ack   (vram_ack)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: word index comes back one cycle after the address.
    always @(posedge clk) rom_rdata <= {22'h0, rom_addr};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic rom_rd(input logic [31:0] addr, input logic poke);
        logic [31:0] exp;
        exp = {22'h0, addr[11:2]};
        i_req = 1'b1; i_we = 1'b0; i_addr = addr; i_wdata = 32'h0;
        step;
        i_req = 1'b0;
        chk("rom_busy", 32'(o_busy), 32'd1);
        chk("rom_addr", 32'(rom_addr), 32'(addr[11:2]));
        chk("rom_ack_c1", 32'(o_ack), 32'd0);
        if (poke) begin
            i_req = 1'b1; i_we = 1'b1; i_addr = 32'hA000_0000;
        end
        step;
        chk("rom_ack_c2", 32'(o_ack), 32'd0);
        step;
        i_req = 1'b0;
        chk("rom_ack", 32'(o_ack), 32'd1);
        chk("rom_err", 32'(o_err), 32'd0);
        chk("rom_data", o_rdata, exp);
        chk("rom_novram", 32'(vram_req), 32'd0);
        exp_rdata = exp;
        last_rom  = addr[11:2];
        step;
        chk("rom_ackdrop", 32'(o_ack), 32'd0);
        chk("rom_idle", 32'(o_busy), 32'd0);
        chk("rom_hold", o_rdata, exp_rdata);
    endtask

    task automatic err_acc(input logic [31:0] addr, input logic we);
        i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = 32'h5A5A_5A5A;
        step;
        i_req = 1'b0;
        chk("err_ack", 32'(o_ack), 32'd1);
        chk("err_err", 32'(o_err), 32'd1);
        chk("err_data", o_rdata, 32'hDEAD_BEEF);
        chk("err_novram", 32'(vram_req), 32'd0);
        chk("err_norom", 32'(rom_addr), 32'(last_rom));
        exp_rdata = 32'hDEAD_BEEF;
        step;
        chk("err_ackdrop", 32'(o_ack), 32'd0);
        chk("err_errdrop", 32'(o_err), 32'd0);
        chk("err_idle", 32'(o_busy), 32'd0);
    endtask

    task automatic vram_acc(input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input int ack_after,
                            input logic [31:0] resp);
        int          hi;
        int          acks;
        int          exp_hi;
        logic        exp_err;
        logic [31:0] exp;
        exp_err = (ack_after == 0);
        exp_hi  = exp_err ? 15 : ack_after;
        if (exp_err)  exp = 32'hDEAD_BEEF;
        else if (!we) exp = resp;
        else          exp = exp_rdata;
        i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata;
        step;
        i_req = 1'b0;
        chk("vr_req", 32'(vram_req), 32'd1);
        chk("vr_we", 32'(vram_we), 32'(we));
        chk("vr_addr", 32'(vram_addr), 32'(addr[13:2]));
        chk("vr_wdata", vram_wdata, wdata);
        chk("vr_busy", 32'(o_busy), 32'd1);
        hi   = 0;
        acks = 0;
        for (int c = 0; c < 40 && vram_req; c++) begin
            hi++;
            if (hi == ack_after) begin
                vram_ack = 1'b1; vram_rdata = resp;
            end
            step;
            vram_ack = 1'b0;
            if (o_ack) acks++;
        end
        chk("vr_reqlen", 32'(hi), 32'(exp_hi));
        chk("vr_nacks", 32'(acks), 32'd1);
        chk("vr_ack", 32'(o_ack), 32'd1);
        chk("vr_err", 32'(o_err), 32'(exp_err));
        chk("vr_data", o_rdata, exp);
        exp_rdata = exp;
        step;
        chk("vr_ackdrop", 32'(o_ack), 32'd0);
        chk("vr_idle", 32'(o_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; i_req = 1'b0; i_we = 1'b0;
        i_addr = 32'h0; i_wdata = 32'h0;
        vram_rdata = 32'h0; vram_ack = 1'b0;
        step;
        step;
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_ack", 32'(o_ack), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_romaddr", 32'(rom_addr), 32'd0);
        chk("rst_vreq", 32'(vram_req), 32'd0);
        chk("rst_vwe", 32'(vram_we), 32'd0);
        chk("rst_vaddr", 32'(vram_addr), 32'd0);
        chk("rst_vwdata", vram_wdata, 32'h0);
        reset     = 1'b1;
        exp_rdata = 32'h0;
        last_rom  = 10'h0;
        step;

        rom_rd(32'hB000_0010, 1'b0);
        vram_acc(32'hA000_0100, 1'b1, 32'h1234_5678, 5, 32'hCAFE_F00D);
        vram_acc(32'hA000_0008, 1'b0, 32'h0, 1, 32'h1122_3344);
        vram_acc(32'hA000_0200, 1'b0, 32'h0, 0, 32'h0);
        vram_acc(32'hA000_3FFC, 1'b0, 32'h0, 15, 32'h0BAD_CAFE);

        err_acc(32'hB000_0002, 1'b0);
        rom_rd(32'hB000_0FFC, 1'b0);
        err_acc(32'hB000_0000, 1'b1);
        err_acc(32'hB000_1000, 1'b0);
        err_acc(32'h4000_0000, 1'b0);
        err_acc(32'hA000_4000, 1'b0);

        rom_rd(32'hB000_0000, 1'b1);
        rom_rd(32'hB000_0004, 1'b0);

        i_req = 1'b1; i_we = 1'b1;
        i_addr = 32'hA000_0010; i_wdata = 32'h7777_0000;
        step;
        i_req = 1'b0;
        chk("mr_req", 32'(vram_req), 32'd1);
        step;
        step;
        step;
        reset = 1'b0;
        step;
        reset = 1'b1;
        chk("mr_vreq", 32'(vram_req), 32'd0);
        chk("mr_ack", 32'(o_ack), 32'd0);
        chk("mr_busy", 32'(o_busy), 32'd0);
        chk("mr_rdata", o_rdata, 32'h0);
        chk("mr_vwe", 32'(vram_we), 32'd0);
        vram_ack = 1'b1; vram_rdata = 32'h9999_9999;
        step;
        vram_ack = 1'b0;
        chk("mr_late_ack", 32'(o_ack), 32'd0);
        chk("mr_late_busy", 32'(o_busy), 32'd0);
        step;
        chk("mr_late_ack2", 32'(o_ack), 32'd0);
        chk("mr_late_data", o_rdata, 32'h0);
        exp_rdata = 32'h0;
        last_rom  = 10'h0;
        rom_rd(32'hB000_0020, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
